// File: rtl/lc3_pkg.sv
// lc3_pkg: shared definitions for the LC-3 memory stage.
//   - Memory-mapped device register addresses (KBSR, KBDR, DSR, DDR, MCR).
//   - mem_state_t: handshake FSM states used by lc3_memory_interface.
// Device decode is only active in builds with LC3_MMIO_EN defined.
package lc3_pkg;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/lc3_mmio_regs.sv
// lc3_mmio_regs: LC-3 memory-mapped device registers.
//   Keyboard status/data (KBSR/KBDR), display status/data (DSR/DDR) and the
//   machine control register (MCR), plus the combinational read mux.
// Build option: LC3_MMIO_EN. When undefined the devices do not exist:
//   kb_ready=0, disp_valid=0, disp_data=0, mcr_run=1, rdata=0.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   access              one-cycle strobe: device access happens at this edge
//   write               1 = write access, 0 = read access
//   addr, wdata         MAR / MDR of the requesting access
//   rdata               read value for addr (sampled by the caller on access)
//   kb_valid/kb_data/kb_ready        keyboard char handshake
//   disp_valid/disp_data/disp_ready  display char handshake
//   mcr_run             MCR[15]
module lc3_mmio_regs #(
    parameter logic MCR_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        access,
    input  logic        write,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        mcr_run
);
    import lc3_pkg::*;

`ifdef LC3_MMIO_EN
    logic       kbsr_flag_reg;
    logic [7:0] kbdr_reg;
    logic       disp_valid_reg;
    logic [7:0] disp_data_reg;
    logic       mcr_run_reg;
    logic       rd_kbdr;
    logic       wr_ddr;
    logic       wr_mcr;
    logic       unused_wdata;

    assign rd_kbdr = access & ~write & (addr == KBDR_ADDR);
    assign wr_ddr  = access &  write & (addr == DDR_ADDR);
    assign wr_mcr  = access &  write & (addr == MCR_ADDR);
    assign unused_wdata = ^wdata[14:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbsr_flag_reg  <= 1'b0;
            kbdr_reg       <= 8'h00;
            disp_valid_reg <= 1'b0;
            disp_data_reg  <= 8'h00;
            mcr_run_reg    <= MCR_RESET;
        end else begin
            // A KBDR read cannot coincide with a char acceptance while the
            // flag is set (kb_ready=0), so the set below never overrides a clear.
            if (rd_kbdr)
                kbsr_flag_reg <= 1'b0;
            if (kb_valid && !kbsr_flag_reg) begin
                kbsr_flag_reg <= 1'b1;
                kbdr_reg      <= kb_data;
            end
            if (disp_valid_reg && disp_ready)
                disp_valid_reg <= 1'b0;
            // A DDR write while a char is still pending is dropped.
            if (wr_ddr && !disp_valid_reg) begin
                disp_valid_reg <= 1'b1;
                disp_data_reg  <= wdata[7:0];
            end
            if (wr_mcr)
                mcr_run_reg <= wdata[15];
        end
    end

    always_comb begin
        rdata = 16'h0000;
        case (addr)
            KBSR_ADDR: rdata = {kbsr_flag_reg, 15'b0};
            KBDR_ADDR: rdata = {8'h00, kbdr_reg};
            DSR_ADDR:  rdata = {~disp_valid_reg, 15'b0};
            MCR_ADDR:  rdata = {mcr_run_reg, 15'b0};
            default:   rdata = 16'h0000;
        endcase
    end

    assign kb_ready   = ~kbsr_flag_reg;
    assign disp_valid = disp_valid_reg;
    assign disp_data  = disp_data_reg;
    assign mcr_run    = mcr_run_reg;
`else
    logic unused_inputs;

    assign unused_inputs = ^{clk, rst_n, access, write, addr, wdata,
                             kb_valid, kb_data, disp_ready, MCR_RESET};
    assign rdata      = 16'h0000;
    assign kb_ready   = 1'b0;
    assign disp_valid = 1'b0;
    assign disp_data  = 8'h00;
    assign mcr_run    = 1'b1;
`endif

endmodule

// File: rtl/lc3_memory_interface.sv
// lc3_memory_interface: LC-3 memory stage (MAR, MDR, MIO_EN/R_W/R handshake).
//   Holds MAR/MDR, runs external word memory through mem_req/mem_ack, decodes
//   device space (>= MMIO_BASE) into lc3_mmio_regs and returns read data to
//   the bus through GateMDR.
// Build option: LC3_MMIO_EN enables device decode. Without it every address
//   goes to external memory and the device outputs are constant.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   bus_in, LDMAR, LDMDR       register loads from the shared bus
//   MIO_EN, R_W, R             access request / direction / completion pulse
//   GateMDR, MDRToBus          MDR onto the bus (zero when not gated)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack  external memory
//   kb_*, disp_*, mcr_run      device handshakes and machine run enable
module lc3_memory_interface #(
    parameter logic [15:0] MMIO_BASE = 16'hFE00,
    parameter logic        MCR_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bus_in,
    input  logic        LDMAR,
    input  logic        LDMDR,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic        GateMDR,
    output logic [15:0] MDRToBus,
    output logic        R,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        mcr_run
);
    import lc3_pkg::*;

    mem_state_t  state_reg;
    logic [15:0] mar_reg;
    logic [15:0] mdr_reg;
    logic [15:0] rd_buf_reg;
    logic        r_reg;
    logic        mem_req_reg;
    logic        mem_we_reg;
    logic        is_mmio;
    logic        mmio_access;
    logic [15:0] mmio_rdata;

`ifdef LC3_MMIO_EN
    assign is_mmio = (mar_reg >= MMIO_BASE);
`else
    logic unused_cfg;
    assign unused_cfg = ^MMIO_BASE;
    assign is_mmio    = 1'b0;
`endif

    // Device accesses complete at the same edge the request is sampled.
    assign mmio_access = (state_reg == IDLE) & MIO_EN & is_mmio;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar_reg <= 16'h0000;
            mdr_reg <= 16'h0000;
        end else begin
            if (LDMAR)
                mar_reg <= bus_in;
            // With MIO_EN set, MDR only takes memory data on the R cycle.
            if (LDMDR) begin
                if (!MIO_EN)
                    mdr_reg <= bus_in;
                else if (r_reg)
                    mdr_reg <= rd_buf_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            r_reg       <= 1'b0;
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
            rd_buf_reg  <= 16'h0000;
        end else begin
            r_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (MIO_EN) begin
                        if (is_mmio) begin
                            if (!R_W)
                                rd_buf_reg <= mmio_rdata;
                            state_reg <= DONE;
                            r_reg     <= 1'b1;
                        end else begin
                            mem_req_reg <= 1'b1;
                            mem_we_reg  <= R_W;
                            state_reg   <= MEM;
                        end
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        if (!mem_we_reg)
                            rd_buf_reg <= mem_rdata;
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        state_reg   <= DONE;
                        r_reg       <= 1'b1;
                    end
                end
                DONE: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    lc3_mmio_regs #(
        .MCR_RESET (MCR_RESET)
    ) u_mmio_regs (
        .clk        (clk),
        .rst_n      (rst_n),
        .access     (mmio_access),
        .write      (R_W),
        .addr       (mar_reg),
        .wdata      (mdr_reg),
        .rdata      (mmio_rdata),
        .kb_valid   (kb_valid),
        .kb_data    (kb_data),
        .kb_ready   (kb_ready),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ready (disp_ready),
        .mcr_run    (mcr_run)
    );

    assign MDRToBus  = GateMDR ? mdr_reg : 16'h0000;
    assign R         = r_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mar_reg;
    assign mem_wdata = mdr_reg;

endmodule
